// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle for sync_fifo_flex: write side, read side,
// status flags and sticky error flags.
//   master: producer/consumer logic (drives wren, datain, rden, clr_err)
//   slave : the FIFO (drives dataout, rdvalid, flags, usedw, errors)
interface sync_fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 4
);
    logic             wren;
    logic [WIDTH-1:0] datain;
    logic             rden;
    logic             clr_err;
    logic [WIDTH-1:0] dataout;
    logic             rdvalid;
    logic             wrfull;
    logic             rdempty;
    logic             almost_full;
    logic             almost_empty;
    logic [PTR:0]     usedw;
    logic             overflow;
    logic             underflow;

    modport master (
        output wren, datain, rden, clr_err,
        input  dataout, rdvalid, wrfull, rdempty,
        input  almost_full, almost_empty, usedw,
        input  overflow, underflow
    );

    modport slave (
        input  wren, datain, rden, clr_err,
        output dataout, rdvalid, wrfull, rdempty,
        output almost_full, almost_empty, usedw,
        output overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO, arbitrary depth, programmable almost flags,
// normal or show-ahead read, exact count, sticky error flags.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : sync_fifo_flex_if.slave (wren/datain, rden/dataout/rdvalid,
//           wrfull, rdempty, almost_full, almost_empty, usedw,
//           overflow, underflow, clr_err)
module sync_fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR       = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int SHOWAHEAD = 0
) (
    input  logic              clk,
    input  logic              reset,
    sync_fifo_flex_if.slave   bus
);

    localparam logic [PTR-1:0] LAST   = PTR'(DEPTH - 1);
    localparam logic [PTR:0]   FULL_N = (PTR+1)'(DEPTH);
    localparam logic [PTR:0]   AF_N   = (PTR+1)'(AFULL_TH);
    localparam logic [PTR:0]   AE_N   = (PTR+1)'(AEMPTY_TH);
    localparam logic [PTR:0]   ONE    = (PTR+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR-1:0]   r_wr_ptr;
    logic [PTR-1:0]   r_rd_ptr;
    logic [PTR:0]     r_usedw;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [PTR-1:0]   w_wr_nxt;
    logic [PTR-1:0]   w_rd_nxt;

    // Flags decode only the registered count.
    assign w_full  = (r_usedw == FULL_N);
    assign w_empty = (r_usedw == '0);

    // A read frees a slot, so a full FIFO may still take a write
    // in the same cycle. An empty FIFO never takes a read.
    assign w_rd_acc = bus.rden & ~w_empty;
    assign w_wr_acc = bus.wren & (~w_full | w_rd_acc);

    // Explicit wrap: depth need not be a power of two.
    assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_nxt;
            if (w_rd_acc) r_rd_ptr <= w_rd_nxt;
            if (w_wr_acc && !w_rd_acc)
                r_usedw <= r_usedw + ONE;
            else if (w_rd_acc && !w_wr_acc)
                r_usedw <= r_usedw - ONE;
            // New error beats a same-cycle clear.
            r_ovf <= (bus.wren & ~w_wr_acc) | (r_ovf & ~bus.clr_err);
            r_udf <= (bus.rden & ~w_rd_acc) | (r_udf & ~bus.clr_err);
        end
    end

    // Storage is not reset. When full, wr_ptr == rd_ptr; the
    // registered read below samples the old word before this write.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc)
            r_mem[r_wr_ptr] <= bus.datain;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_sa
            assign bus.dataout = r_mem[r_rd_ptr];
            assign bus.rdvalid = ~w_empty;
        end else begin : g_nr
            logic [WIDTH-1:0] r_dout;
            logic             r_rdvalid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dout    <= '0;
                    r_rdvalid <= 1'b0;
                end else begin
                    r_rdvalid <= w_rd_acc;
                    if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign bus.dataout = r_dout;
            assign bus.rdvalid = r_rdvalid;
        end
    endgenerate

    assign bus.wrfull       = w_full;
    assign bus.rdempty      = w_empty;
    assign bus.almost_full  = (r_usedw >= AF_N);
    assign bus.almost_empty = (r_usedw <= AE_N);
    assign bus.usedw        = r_usedw;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed testbench for sync_fifo_flex: DEPTH=16 normal mode,
// DEPTH=12 normal mode (wrap), DEPTH=16 show-ahead mode.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.WIDTH(8), .PTR(4)) f0 ();
    sync_fifo_flex_if #(.WIDTH(8), .PTR(4)) f1 ();
    sync_fifo_flex_if #(.WIDTH(8), .PTR(4)) f2 ();

    sync_fifo_flex #(
        .WIDTH(8), .DEPTH(16), .PTR(4),
        .AFULL_TH(12), .AEMPTY_TH(2), .SHOWAHEAD(0)
    ) u0 (
        .clk(clk), .reset(rst0), .bus(f0)
    );

    sync_fifo_flex #(
        .WIDTH(8), .DEPTH(12), .PTR(4),
        .AFULL_TH(10), .AEMPTY_TH(3), .SHOWAHEAD(0)
    ) u1 (
        .clk(clk), .reset(rst1), .bus(f1)
    );

    sync_fifo_flex #(
        .WIDTH(8), .DEPTH(16), .PTR(4),
        .AFULL_TH(12), .AEMPTY_TH(2), .SHOWAHEAD(1)
    ) u2 (
        .clk(clk), .reset(rst2), .bus(f2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        tick();
        n_chk++; if (f0.usedw !== 5'd0) $display("FAIL rst_usedw: got %0d want 0", f0.usedw); else n_pass++;
        n_chk++; if ({f0.rdempty, f0.wrfull, f0.almost_empty, f0.almost_full} !== 4'b1010)
            $display("FAIL rst_flags: got %b want 1010", {f0.rdempty, f0.wrfull, f0.almost_empty, f0.almost_full}); else n_pass++;
        n_chk++; if ({f0.rdvalid, f0.overflow, f0.underflow} !== 3'b000)
            $display("FAIL rst_valid_err: got %b want 000", {f0.rdvalid, f0.overflow, f0.underflow}); else n_pass++;
        n_chk++; if (f0.dataout !== 8'h00) $display("FAIL rst_dataout: got %h want 00", f0.dataout); else n_pass++;
        n_chk++; if (f1.rdempty !== 1'b1) $display("FAIL rst_u1_empty: got %b want 1", f1.rdempty); else n_pass++;
        n_chk++; if (f2.rdvalid !== 1'b0) $display("FAIL rst_u2_rdvalid: got %b want 0", f2.rdvalid); else n_pass++;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            f0.wren = 1'b1;
            f0.datain = 8'(i);
            tick();
            n_chk++; if (f0.usedw !== 5'(i + 1)) $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, f0.usedw, i + 1); else n_pass++;
            n_chk++; if (f0.almost_full !== (i >= 11)) $display("FAIL fill_afull[%0d]: got %b want %b", i, f0.almost_full, (i >= 11)); else n_pass++;
            n_chk++; if (f0.wrfull !== (i == 15)) $display("FAIL fill_full[%0d]: got %b want %b", i, f0.wrfull, (i == 15)); else n_pass++;
        end
        f0.wren = 1'b0;
        n_chk++; if (f0.overflow !== 1'b0) $display("FAIL fill_ovf: got %b want 0", f0.overflow); else n_pass++;
    endtask

    task automatic test_overflow();
        f0.wren = 1'b1;
        f0.datain = 8'hAA;
        tick();
        f0.wren = 1'b0;
        n_chk++; if (f0.usedw !== 5'd16) $display("FAIL ovf_usedw: got %0d want 16", f0.usedw); else n_pass++;
        n_chk++; if (f0.overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", f0.overflow); else n_pass++;
        tick();
        n_chk++; if (f0.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", f0.overflow); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            f0.rden = 1'b1;
            tick();
            n_chk++; if (f0.dataout !== 8'(i) || f0.rdvalid !== 1'b1)
                $display("FAIL drain_data[%0d]: got %h/%b want %h/1", i, f0.dataout, f0.rdvalid, 8'(i)); else n_pass++;
            n_chk++; if (f0.usedw !== 5'(15 - i)) $display("FAIL drain_usedw[%0d]: got %0d want %0d", i, f0.usedw, 15 - i); else n_pass++;
            n_chk++; if (f0.almost_empty !== (i >= 13)) $display("FAIL drain_aempty[%0d]: got %b want %b", i, f0.almost_empty, (i >= 13)); else n_pass++;
        end
        f0.rden = 1'b0;
        tick();
        n_chk++; if ({f0.rdvalid, f0.rdempty} !== 2'b01) $display("FAIL drain_idle: got %b want 01", {f0.rdvalid, f0.rdempty}); else n_pass++;
        n_chk++; if ({f0.overflow, f0.underflow} !== 2'b10) $display("FAIL drain_err: got %b want 10", {f0.overflow, f0.underflow}); else n_pass++;
        f0.clr_err = 1'b1;
        tick();
        f0.clr_err = 1'b0;
        n_chk++; if (f0.overflow !== 1'b0) $display("FAIL clr_ovf: got %b want 0", f0.overflow); else n_pass++;
    endtask

    task automatic test_underflow();
        f0.rden = 1'b1;
        tick();
        f0.rden = 1'b0;
        n_chk++; if ({f0.underflow, f0.rdvalid} !== 2'b10) $display("FAIL udf_set: got %b want 10", {f0.underflow, f0.rdvalid}); else n_pass++;
        n_chk++; if (f0.usedw !== 5'd0) $display("FAIL udf_usedw: got %0d want 0", f0.usedw); else n_pass++;
        f0.clr_err = 1'b1;
        f0.rden = 1'b1;
        tick();
        f0.clr_err = 1'b0;
        f0.rden = 1'b0;
        n_chk++; if (f0.underflow !== 1'b1) $display("FAIL udf_set_wins: got %b want 1", f0.underflow); else n_pass++;
        f0.wren = 1'b1;
        f0.rden = 1'b1;
        f0.datain = 8'h3C;
        tick();
        f0.wren = 1'b0;
        f0.rden = 1'b0;
        n_chk++; if ({f0.usedw, f0.rdvalid} !== {5'd1, 1'b0}) $display("FAIL empty_wr_rd: got %0d/%b want 1/0", f0.usedw, f0.rdvalid); else n_pass++;
        f0.rden = 1'b1;
        tick();
        f0.rden = 1'b0;
        n_chk++; if ({f0.dataout, f0.rdvalid} !== {8'h3C, 1'b1}) $display("FAIL empty_wr_rd_data: got %h/%b want 3c/1", f0.dataout, f0.rdvalid); else n_pass++;
        n_chk++; if (f0.usedw !== 5'd0) $display("FAIL empty_wr_rd_usedw: got %0d want 0", f0.usedw); else n_pass++;
        f0.clr_err = 1'b1;
        tick();
        f0.clr_err = 1'b0;
        n_chk++; if (f0.underflow !== 1'b0) $display("FAIL clr_udf: got %b want 0", f0.underflow); else n_pass++;
    endtask

    task automatic test_full_rw();
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            f0.wren = 1'b1;
            f0.datain = 8'h40 + 8'(i);
            q.push_back(8'h40 + 8'(i));
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            f0.wren = 1'b1;
            f0.rden = 1'b1;
            f0.datain = 8'h80 + 8'(k);
            tick();
            exp = q.pop_front();
            q.push_back(8'h80 + 8'(k));
            n_chk++; if (f0.dataout !== exp) $display("FAIL fullrw_data[%0d]: got %h want %h", k, f0.dataout, exp); else n_pass++;
            n_chk++; if ({f0.usedw, f0.overflow, f0.underflow} !== {5'd16, 2'b00})
                $display("FAIL fullrw_state[%0d]: got %0d/%b%b want 16/00", k, f0.usedw, f0.overflow, f0.underflow); else n_pass++;
        end
        f0.wren = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = q.pop_front();
            n_chk++; if (f0.dataout !== exp) $display("FAIL fullrw_drain[%0d]: got %h want %h", i, f0.dataout, exp); else n_pass++;
        end
        f0.rden = 1'b0;
        tick();
        n_chk++; if (f0.rdempty !== 1'b1) $display("FAIL fullrw_empty: got %b want 1", f0.rdempty); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] exp;
        logic [7:0] d;
        int         w = 0;
        int         occ = 0;
        logic       rd;
        for (int i = 0; i < 3; i++) begin
            f1.wren = 1'b1;
            d = 8'(w * 7 + 1);
            f1.datain = d;
            q.push_back(d);
            w++;
            occ++;
            tick();
        end
        for (int k = 0; k < 37; k++) begin
            rd = (k % 5 != 0);
            d = 8'(w * 7 + 1);
            f1.wren = 1'b1;
            f1.rden = rd;
            f1.datain = d;
            w++;
            tick();
            if (rd) begin
                exp = q.pop_front();
                n_chk++; if ({f1.dataout, f1.rdvalid} !== {exp, 1'b1})
                    $display("FAIL wrap_data[%0d]: got %h/%b want %h/1", k, f1.dataout, f1.rdvalid, exp); else n_pass++;
            end else begin
                occ++;
                n_chk++; if (f1.rdvalid !== 1'b0) $display("FAIL wrap_novalid[%0d]: got %b want 0", k, f1.rdvalid); else n_pass++;
            end
            q.push_back(d);
            n_chk++; if (f1.usedw !== 5'(occ)) $display("FAIL wrap_usedw[%0d]: got %0d want %0d", k, f1.usedw, occ); else n_pass++;
        end
        f1.wren = 1'b0;
        f1.rden = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            exp = q.pop_front();
            n_chk++; if (f1.dataout !== exp) $display("FAIL wrap_drain[%0d]: got %h want %h", i, f1.dataout, exp); else n_pass++;
        end
        f1.rden = 1'b0;
        n_chk++; if ({f1.rdempty, f1.overflow, f1.underflow} !== 3'b100)
            $display("FAIL wrap_end: got %b want 100", {f1.rdempty, f1.overflow, f1.underflow}); else n_pass++;
    endtask

    task automatic test_showahead();
        f2.wren = 1'b1;
        f2.datain = 8'h5C;
        tick();
        f2.wren = 1'b0;
        n_chk++; if ({f2.dataout, f2.rdvalid} !== {8'h5C, 1'b1}) $display("FAIL sa_head: got %h/%b want 5c/1", f2.dataout, f2.rdvalid); else n_pass++;
        f2.rden = 1'b1;
        tick();
        f2.rden = 1'b0;
        n_chk++; if ({f2.rdempty, f2.rdvalid} !== 2'b10) $display("FAIL sa_pop: got %b want 10", {f2.rdempty, f2.rdvalid}); else n_pass++;
        f2.wren = 1'b1;
        f2.datain = 8'hA1;
        tick();
        f2.datain = 8'hA2;
        tick();
        f2.wren = 1'b0;
        n_chk++; if ({f2.dataout, f2.usedw} !== {8'hA1, 5'd2}) $display("FAIL sa_two: got %h/%0d want a1/2", f2.dataout, f2.usedw); else n_pass++;
        f2.rden = 1'b1;
        tick();
        f2.rden = 1'b0;
        n_chk++; if ({f2.dataout, f2.usedw} !== {8'hA2, 5'd1}) $display("FAIL sa_next: got %h/%0d want a2/1", f2.dataout, f2.usedw); else n_pass++;
    endtask

    task automatic test_reset_mid();
        f0.rden = 1'b1;
        tick();
        f0.rden = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f0.wren = 1'b1;
            f0.datain = 8'h60 + 8'(i);
            tick();
        end
        f0.wren = 1'b0;
        f0.rden = 1'b1;
        tick();
        f0.rden = 1'b0;
        n_chk++; if ({f0.usedw, f0.dataout, f0.underflow} !== {5'd7, 8'h60, 1'b1})
            $display("FAIL mid_pre: got %0d/%h/%b want 7/60/1", f0.usedw, f0.dataout, f0.underflow); else n_pass++;
        rst0 = 1'b1;
        f0.wren = 1'b1;
        f0.rden = 1'b1;
        f0.datain = 8'hEE;
        tick();
        rst0 = 1'b0;
        f0.wren = 1'b0;
        f0.rden = 1'b0;
        n_chk++; if (f0.usedw !== 5'd0) $display("FAIL mid_usedw: got %0d want 0", f0.usedw); else n_pass++;
        n_chk++; if ({f0.rdempty, f0.wrfull, f0.almost_empty, f0.almost_full} !== 4'b1010)
            $display("FAIL mid_flags: got %b want 1010", {f0.rdempty, f0.wrfull, f0.almost_empty, f0.almost_full}); else n_pass++;
        n_chk++; if ({f0.dataout, f0.rdvalid, f0.overflow, f0.underflow} !== {8'h00, 3'b000})
            $display("FAIL mid_out: got %h/%b%b%b want 00/000", f0.dataout, f0.rdvalid, f0.overflow, f0.underflow); else n_pass++;
        f0.wren = 1'b1;
        f0.datain = 8'h77;
        tick();
        f0.wren = 1'b0;
        f0.rden = 1'b1;
        tick();
        f0.rden = 1'b0;
        n_chk++; if ({f0.dataout, f0.rdvalid, f0.usedw} !== {8'h77, 1'b1, 5'd0})
            $display("FAIL mid_roundtrip: got %h/%b/%0d want 77/1/0", f0.dataout, f0.rdvalid, f0.usedw); else n_pass++;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        f0.wren = 1'b0; f0.rden = 1'b0; f0.clr_err = 1'b0; f0.datain = '0;
        f1.wren = 1'b0; f1.rden = 1'b0; f1.clr_err = 1'b0; f1.datain = '0;
        f2.wren = 1'b0; f2.rden = 1'b0; f2.clr_err = 1'b0; f2.datain = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_showahead();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
